// File: rtl/dram_refresh_ctrl.sv
// DDR4 refresh scheduler: times tREFI, tracks owed refreshes, and issues
// PRECHARGE-all / REFRESH on the command bus once the main FSM grants it.
module dram_refresh_ctrl #(
  parameter int T_REFI       = 250,
  parameter int T_RFC        = 172,
  parameter int T_RP         = 10,
  parameter int MAX_POSTPONE = 8,
  parameter int CNT_W        = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       init_done,
  input  logic       bank_open,
  input  logic       ref_gnt,
  output logic       ref_req,
  output logic       ref_urgent,
  output logic       cmd_valid,
  output logic       cmd_is_pre,
  output logic       ref_busy,
  output logic       ref_done,
  output logic [3:0] backlog,
  output logic       ref_overflow
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PRE,
    PRE_WAIT,
    REF,
    REF_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);
  localparam logic [CNT_W-1:0] RP_LOAD   = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] RFC_LOAD  = CNT_W'(T_RFC - 2);
  localparam logic [3:0]       BL_SAT    = 4'(MAX_POSTPONE + 1);
  localparam logic [3:0]       BL_URG    = 4'(MAX_POSTPONE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] intv_q, intv_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [3:0]       backlog_q, backlog_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             tick;
  logic             ref_cmd;

  assign tick    = init_done && (intv_q == REFI_LAST);
  assign ref_cmd = (state_q == REF);

  always_comb begin
    intv_d = intv_q + CNT_W'(1);
    if (!init_done || tick) begin
      intv_d = '0;
    end
  end

  // A tick and a REF strobe in the same cycle cancel; saturation makes the
  // tick sticky-flag an overflow instead of growing the backlog.
  always_comb begin
    backlog_d = backlog_q;
    ovf_d     = ovf_q;
    if (!init_done) begin
      backlog_d = '0;
    end else if (tick && !ref_cmd) begin
      if (backlog_q == BL_SAT) begin
        ovf_d = 1'b1;
      end else begin
        backlog_d = backlog_q + 4'd1;
      end
    end else if (ref_cmd && !tick && backlog_q != '0) begin
      backlog_d = backlog_q - 4'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    done_d     = 1'b0;
    ref_req    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_is_pre = 1'b0;
    ref_busy   = 1'b0;
    case (state_q)
      IDLE: begin
        // Looking at the tick as well lets the request rise with the backlog.
        if (backlog_q != '0 || tick) begin
          state_d = REQ;
        end
      end
      REQ: begin
        ref_req = 1'b1;
        if (ref_gnt) begin
          state_d = bank_open ? PRE : REF;
        end
      end
      PRE: begin
        cmd_valid  = 1'b1;
        cmd_is_pre = 1'b1;
        ref_busy   = 1'b1;
        wait_d     = RP_LOAD;
        state_d    = PRE_WAIT;
      end
      PRE_WAIT: begin
        ref_busy = 1'b1;
        if (wait_q == '0) begin
          state_d = REF;
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      REF: begin
        cmd_valid = 1'b1;
        ref_busy  = 1'b1;
        wait_d    = RFC_LOAD;
        state_d   = REF_WAIT;
      end
      REF_WAIT: begin
        ref_busy = 1'b1;
        if (wait_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      intv_q    <= '0;
      wait_q    <= '0;
      backlog_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      intv_q    <= intv_d;
      wait_q    <= wait_d;
      backlog_q <= backlog_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign ref_done     = done_q;
  assign backlog      = backlog_q;
  assign ref_overflow = ovf_q;
  assign ref_urgent   = (backlog_q >= BL_URG);

endmodule

// File: doc/dram_refresh_ctrl.md
Name: dram_refresh_ctrl

Overview:
Refresh scheduler for the DDR4 controller. It times tREFI intervals after initialization and keeps a backlog of owed refreshes, up to 8 postponed per JEDEC, with a hard limit of 9×tREFI. It requests the command bus from the main command FSM and, once granted, sequences PRECHARGE-all (when any bank is open) then REFRESH, honouring tRP and tRFC. Its outputs feed the command mux that encodes {cs, act, ras, cas, we}.

Parameters:
T_REFI, 250, refresh interval in clocks
T_RFC, 172, REFRESH-to-next-command time in clocks
T_RP, 10, PRECHARGE-to-REFRESH time in clocks (≥2)
MAX_POSTPONE, 8, backlog level that forces urgency
CNT_W, 12, width of interval/wait counters (must hold max(T_REFI, T_RFC))

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
init_done  in  1  init sequence (through ZQ_CL) complete; enables interval timing
bank_open  in  1  ≥1 bank has an open row; sampled in the grant cycle
ref_gnt  in  1  main FSM grants command bus to this block
ref_req  out  1  request for command bus
ref_urgent  out  1  backlog ≥ MAX_POSTPONE; main FSM must grant before new ACTIVATE
cmd_valid  out  1  one-cycle command strobe
cmd_is_pre  out  1  1 = PRECHARGE-all, 0 = REFRESH (meaningful only with cmd_valid)
ref_busy  out  1  block owns command bus
ref_done  out  1  one-cycle pulse at end of tRFC
backlog  out  4  owed refreshes, 0..MAX_POSTPONE+1
ref_overflow  out  1  sticky: tREFI tick while backlog saturated

Behaviour:
- Reset: state IDLE. All outputs 0, interval counter 0, wait counter 0. RST mid-sequence aborts on the same edge; cmd_valid is 0 on the following cycle.
- Interval counter:
  - Held at 0 while init_done=0; backlog is also held at 0.
  - Otherwise it increments each cycle. At value T_REFI-1 it wraps to 0 and generates a tick.
  - The first tick occurs T_REFI cycles after init_done rises.
- Backlog arithmetic:
  - +1 on tick; -1 in the REF command cycle.
  - Tick and REF in the same cycle: net unchanged.
  - Saturates at MAX_POSTPONE+1. A tick while saturated (and no same-cycle REF) sets ref_overflow, cleared only by RST.
- ref_urgent = (backlog ≥ MAX_POSTPONE), combinational from the backlog register.
- FSM states: IDLE, REQ, PRE, PRE_WAIT, REF, REF_WAIT.
  - IDLE: if backlog>0 → REQ.
  - REQ: ref_req=1, held until grant; never withdrawn. ref_gnt=1 → PRE if bank_open=1, else → REF. ref_gnt in any other state is ignored.
  - PRE: cmd_valid=1, cmd_is_pre=1 for one cycle → PRE_WAIT with wait count T_RP-2.
  - PRE_WAIT: count down to 0 → REF. REF strobe lands exactly T_RP cycles after the PRE strobe.
  - REF: cmd_valid=1, cmd_is_pre=0 for one cycle; backlog decrement → REF_WAIT with wait count T_RFC-2.
  - REF_WAIT: count down to 0 → IDLE, ref_done=1 in that transition cycle. ref_done is exactly T_RFC cycles after the REF strobe.
- ref_busy=1 in PRE, PRE_WAIT, REF, REF_WAIT. 0 in IDLE/REQ.
- Grant at cycle t: first strobe at t+1.
- Back-to-back refreshes: after IDLE, if backlog>0 go REQ next cycle. Each refresh requires a fresh grant.
- Ticks continue counting during the refresh sequence.
- init_done falling: counter and backlog clear. An in-flight sequence completes.

Test Plan:
- Bench overrides: T_REFI=20, T_RFC=8, T_RP=3, MAX_POSTPONE=8.
- Reset then init_done=1 at cycle 0 → backlog=1 and ref_req=1 at cycle 20. Only RST is applied: all outputs 0.
- ref_gnt at t with bank_open=1 → PRE strobe t+1, REF strobe t+4, ref_done t+12. ref_busy high t+1..t+11. backlog 1→0 at REF.
- ref_gnt with bank_open=0 → REF strobe at t+1, no PRE strobe, ref_done at t+9.
- Withhold ref_gnt 180 cycles → backlog reaches 8 with ref_urgent=1, then 9. The next tick sets ref_overflow, and backlog stays 9.
- Tick coincident with REF strobe, backlog=3 → backlog remains 3. RST asserted in PRE_WAIT → next cycle IDLE, backlog=0, cmd_valid=0, no REF strobe.
